// File: rtl/pwm_capture_if.sv
// pwm_capture_if: control inputs and measurement results of one pwm_capture channel
interface pwm_capture_if #(parameter int W = 16);
  logic enable;
  logic pwm_in;
  logic irq_clr;
  logic [W-1:0] high_cnt;
  logic [W-1:0] period_cnt;
  logic [7:0] duty_pct;
  logic valid;
  logic timeout;
  logic overrun;
  logic irq;
  modport master (
    output enable, pwm_in, irq_clr,
    input high_cnt, period_cnt, duty_pct, valid, timeout, overrun, irq
  );
  modport slave (
    input enable, pwm_in, irq_clr,
    output high_cnt, period_cnt, duty_pct, valid, timeout, overrun, irq
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time, period and duty percent of a sampled PWM line, with timeout/overrun flags
module pwm_capture #(
  parameter int W = 16,
  parameter int TIMEOUT_CYC = 4000
) (
  input logic clk_100,
  input logic rst_n,
  pwm_capture_if.slave bus
);
  localparam int NW = W + 7;
  localparam int DW = $clog2(NW + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;
  state_t state;
  logic s1, s2, s3;
  logic [W-1:0] cnt, hi_lat, d_hi, den, rem, diff;
  logic [TW-1:0] tcnt;
  logic [NW-1:0] n;
  logic [DW-1:0] dcnt;
  logic fin;
  logic rise, fall, fire, launch, busy, abort, done, ge;
  logic [W:0] r_sh;
  // edge detection, timeout and divider step decode
  always_comb begin
    rise = s2 & ~s3;
    fall = ~s2 & s3;
    fire = bus.enable && state != IDLE && !rise && !fall && tcnt == TW'(TIMEOUT_CYC - 1);
    busy = dcnt != '0 || fin;
    launch = bus.enable && state == LOW && rise;
    abort = !bus.enable || fire;
    done = fin && !abort;
    r_sh = {rem, n[NW-1]};
    ge = r_sh >= {1'b0, den};
    diff = r_sh[W-1:0] - den;
  end
  // two-flop synchroniser followed by the edge register
  always_ff @(posedge clk_100 or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  // measurement FSM: the rising-edge cycle counts as 1, a closing rise also opens the next period
  always_ff @(posedge clk_100 or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      hi_lat <= '0;
      tcnt <= '0;
    end else if (abort) begin
      state <= bus.enable ? ARM : IDLE;
      cnt <= '0;
      tcnt <= '0;
    end else begin
      state <= state == IDLE ? ARM : rise ? HIGH : (fall && state == HIGH) ? LOW : state;
      cnt <= state == IDLE ? '0 : rise ? W'(1) : state == ARM ? '0 : cnt == '1 ? cnt : cnt + 1'b1;
      tcnt <= (state == IDLE || rise || fall) ? '0 : tcnt + 1'b1;
      if (state == HIGH && fall) hi_lat <= cnt;
    end
  // restoring divider, one quotient bit per cycle; the quotient shifts into the numerator register
  always_ff @(posedge clk_100 or negedge rst_n)
    if (!rst_n) begin
      dcnt <= '0;
      fin <= 1'b0;
      n <= '0;
      rem <= '0;
      den <= '0;
      d_hi <= '0;
    end else if (abort) begin
      dcnt <= '0;
      fin <= 1'b0;
    end else if (launch && !busy) begin
      n <= NW'(hi_lat) * NW'(100);
      rem <= '0;
      den <= cnt;
      d_hi <= hi_lat;
      dcnt <= DW'(NW);
      fin <= 1'b0;
    end else begin
      fin <= dcnt == DW'(1);
      if (dcnt != '0) begin
        n <= {n[NW-2:0], ge};
        rem <= ge ? diff : r_sh[W-1:0];
        dcnt <= dcnt - 1'b1;
      end
    end
  // result registers and sticky flags; a new set beats a simultaneous clear
  always_ff @(posedge clk_100 or negedge rst_n)
    if (!rst_n) begin
      bus.high_cnt <= '0;
      bus.period_cnt <= '0;
      bus.duty_pct <= '0;
      bus.valid <= 1'b0;
      bus.timeout <= 1'b0;
      bus.overrun <= 1'b0;
      bus.irq <= 1'b0;
    end else begin
      bus.valid <= done || fire;
      if (fire) begin
        bus.high_cnt <= '0;
        bus.period_cnt <= '0;
        bus.duty_pct <= s2 ? 8'd100 : 8'd0;
        bus.timeout <= 1'b1;
      end else if (done) begin
        bus.high_cnt <= d_hi;
        bus.period_cnt <= den;
        bus.duty_pct <= n > NW'(100) ? 8'd100 : n[7:0];
        bus.timeout <= 1'b0;
      end
      bus.irq <= done || fire || (bus.irq && !bus.irq_clr);
      bus.overrun <= (launch && busy) || (bus.overrun && !bus.irq_clr);
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: random and directed PWM stimulus checked against a period-level reference model
module tb_pwm_capture;
  localparam int TO = 4000;
  localparam int LAT = 27;
  localparam int GAP = 25;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pwm_capture_if #(.W(16)) bus ();
  pwm_capture #(.W(16), .TIMEOUT_CYC(TO)) dut (.clk_100(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {int hi; int per; int duty; bit to; int cyc;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, nvalid = 0, nrise = 0;
  int rise_c = 0, hi_len = 0, last_acc = -1000;
  bit started = 1'b0, en_m = 1'b0, exp_ov = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  // every valid must match the oldest outstanding expected result, including its cycle
  always @(negedge clk)
    if (rst_n && bus.valid) begin
      exp_t e;
      nvalid++;
      if (q.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("high_cnt", bus.high_cnt, e.hi);
        chk("period_cnt", bus.period_cnt, e.per);
        chk("duty_pct", bus.duty_pct, e.duty);
        chk("timeout", bus.timeout, e.to);
        chk("valid_cycle", cyc, e.cyc);
      end
    end
  // pin-level model: a measured rise closes the previous period; results need GAP cycles between launches
  task automatic pin_to(input logic v);
    int per, d;
    if (v && !bus.pwm_in) begin
      nrise++;
      if (started && en_m) begin
        if (cyc - last_acc >= GAP) begin
          per = cyc - rise_c;
          d = hi_len * 100 / per;
          q.push_back('{hi_len, per, (d > 100) ? 100 : d, 1'b0, cyc + LAT});
          last_acc = cyc;
        end else exp_ov = 1'b1;
      end
      started = en_m;
      rise_c = cyc;
    end else if (!v && bus.pwm_in) hi_len = cyc - rise_c;
    bus.pwm_in = v;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic period(input int hi, input int p);
    pin_to(1'b1);
    idle(hi);
    pin_to(1'b0);
    idle(p - hi);
  endtask
  task automatic stuck(input logic v, input int n);
    int c;
    pin_to(v);
    c = cyc;
    for (int k = 1; 3 + TO * k < n; k++) q.push_back('{0, 0, v ? 100 : 0, 1'b1, c + 3 + TO * k});
    idle(n);
    started = 1'b0;
    last_acc = -1000;
  endtask
  task automatic clear_irq();
    bus.irq_clr = 1'b1;
    idle(1);
    bus.irq_clr = 1'b0;
    exp_ov = 1'b0;
    chk("irq_cleared", bus.irq, 0);
    chk("overrun_cleared", bus.overrun, 0);
  endtask
  initial begin
    int p, h, v0, r0, c0;
    bus.enable = 1'b0;
    bus.pwm_in = 1'b0;
    bus.irq_clr = 1'b0;
    idle(3);
    chk("reset_outputs", {bus.high_cnt, bus.period_cnt, bus.duty_pct, bus.valid, bus.timeout, bus.overrun, bus.irq}, 0);
    rst_n = 1'b1;
    idle(2);
    bus.enable = 1'b1;
    en_m = 1'b1;
    idle(3);
    repeat (3) period(50, 100);
    chk("t1_irq", bus.irq, 1);
    repeat (3) period(25, 100);
    repeat (3) period(80, 100);
    pin_to(1'b1);
    c0 = cyc;
    idle(LAT - 1 - (cyc - c0));
    bus.irq_clr = 1'b1;
    idle(1);
    bus.irq_clr = 1'b0;
    chk("irq_set_wins", bus.irq, 1);
    idle(53);
    pin_to(1'b0);
    idle(20);
    clear_irq();
    repeat (12) period(1, 3);
    repeat (3) period(39, 40);
    chk("t3_overrun_set", bus.overrun, exp_ov);
    clear_irq();
    v0 = nvalid;
    r0 = nrise;
    repeat (8) period(5, 10);
    idle(40);
    chk("t3_fewer_valids", (nvalid - v0) < (nrise - r0), 1);
    chk("t3_overrun_10", bus.overrun, exp_ov);
    clear_irq();
    repeat (2) period(50, 100);
    pin_to(1'b1);
    idle(10);
    bus.enable = 1'b0;
    en_m = 1'b0;
    started = 1'b0;
    last_acc = -1000;
    void'(q.pop_back());
    v0 = nvalid;
    idle(40);
    pin_to(1'b0);
    idle(50);
    repeat (2) period(50, 100);
    chk("t5_no_valid_disabled", nvalid - v0, 0);
    bus.enable = 1'b1;
    en_m = 1'b1;
    repeat (3) period(30, 100);
    repeat (2) period(50, 100);
    pin_to(1'b1);
    idle(20);
    chk("t6_irq_before_reset", bus.irq, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset", {bus.high_cnt, bus.period_cnt, bus.duty_pct, bus.valid, bus.timeout, bus.overrun, bus.irq}, 0);
    q.delete();
    started = 1'b0;
    last_acc = -1000;
    exp_ov = 1'b0;
    pin_to(1'b0);
    idle(5);
    rst_n = 1'b1;
    repeat (3) period(50, 100);
    repeat (20) begin
      p = int'($urandom_range(25, 300));
      h = int'($urandom_range(1, p - 1));
      period(h, p);
    end
    stuck(1'b1, 8100);
    chk("t4_timeout_high", bus.timeout, 1);
    chk("t4_duty_high", bus.duty_pct, 100);
    stuck(1'b0, 4100);
    chk("t4_timeout_low", bus.timeout, 1);
    chk("t4_duty_low", bus.duty_pct, 0);
    chk("t4_counts_zero", {bus.high_cnt, bus.period_cnt}, 0);
    repeat (3) period(50, 100);
    idle(40);
    chk("t4_timeout_cleared", bus.timeout, 0);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
